// File: rtl/alu8_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU command sequencer.
// Optional feature macro: ALU8_SEQ_CHAIN_EN (adds the result-chaining input).
package alu8_seq_pkg;

  localparam int DATA_W      = 8;
  localparam int NIB_W       = 4;
  localparam int OP_W        = 4;
  localparam int CNT_W       = 4;
  localparam int CMD_NIBBLES = 5;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_AL   = 3'd1,
    S_AH   = 3'd2,
    S_BL   = 3'd3,
    S_BH   = 3'd4,
    S_EXEC = 3'd5,
    S_DONE = 3'd6
  } seq_state_e;

  // True in every state that takes a nibble from the input bus
  function automatic logic takesNibble(input seq_state_e s);
    return (s == S_OP) || (s == S_AL) || (s == S_AH) || (s == S_BL) || (s == S_BH);
  endfunction

endpackage

// File: rtl/alu8_op_sequencer_if.sv
// Bus bundle between the I/O pins, the sequencer and the external ALU.
// Optional feature macro: ALU8_SEQ_CHAIN_EN (adds the chain signal).
interface alu8_op_sequencer_if;
  import alu8_seq_pkg::*;

  logic [NIB_W-1:0]  nib_in;
  logic              nib_valid;
  logic              nib_ready;
  logic [DATA_W-1:0] res_out;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
`ifdef ALU8_SEQ_CHAIN_EN
  logic              chain;
`endif

  modport master (
`ifdef ALU8_SEQ_CHAIN_EN
    output chain,
`endif
    output nib_in, nib_valid, res_ready, alu_result,
    input  nib_ready, res_out, res_valid, busy, alu_a, alu_b, alu_op
  );

  modport slave (
`ifdef ALU8_SEQ_CHAIN_EN
    input  chain,
`endif
    input  nib_in, nib_valid, res_ready, alu_result,
    output nib_ready, res_out, res_valid, busy, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu8_nib_collector.sv
// Nibble-to-byte assembler: merges one nibble into the low or high half of a byte.
// Shared by the A and B operand paths; the caller selects which byte feeds it.
module alu8_nib_collector
  import alu8_seq_pkg::*;
(
  input  logic [DATA_W-1:0] byte_i,
  input  logic [NIB_W-1:0]  nib_i,
  input  logic              hi_sel_i,
  input  logic              load_i,
  output logic [DATA_W-1:0] byte_o
);

  // Replace the selected half with the incoming nibble, otherwise pass the byte through
  always_comb begin
    byte_o = byte_i;
    if (load_i) begin
      if (hi_sel_i) begin
        byte_o[DATA_W-1:NIB_W] = nib_i;
      end else begin
        byte_o[NIB_W-1:0] = nib_i;
      end
    end
  end

endmodule

// File: rtl/alu8_op_sequencer.sv
// Nibble-serial command sequencer in front of an external 8-bit ALU.
// Collects opcode, A and B over a 4-bit bus, holds them on the ALU for
// EXEC_CYCLES, captures the result and offers it on a valid/ready handshake.
// Optional feature macro: ALU8_SEQ_CHAIN_EN (chain=1 reuses the last result as A).
module alu8_op_sequencer
  import alu8_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input logic                clk,
  input logic                rst_n,
  alu8_op_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  seq_state_e        state_q,    state_d;
  logic [CNT_W-1:0]  execCnt_q,  execCnt_d;
  logic [DATA_W-1:0] aluA_q,     aluA_d;
  logic [DATA_W-1:0] aluB_q,     aluB_d;
  logic [OP_W-1:0]   aluOp_q,    aluOp_d;
  logic [DATA_W-1:0] resOut_q,   resOut_d;
  logic              resValid_q, resValid_d;

  logic              nibReady;
  logic [DATA_W-1:0] collSrc;
  logic              collHi;
  logic              collLoad;
  logic [DATA_W-1:0] collByte;

  assign nibReady = takesNibble(state_q);

  // Next-state and register-update logic for the load/exec/done sequence
  always_comb begin
    state_d    = state_q;
    execCnt_d  = execCnt_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluOp_d    = aluOp_q;
    resOut_d   = resOut_q;
    resValid_d = resValid_q;
    collSrc    = aluA_q;
    collHi     = 1'b0;
    collLoad   = 1'b0;

    case (state_q)
      S_OP: begin
        if (bus.nib_valid) begin
          aluOp_d = bus.nib_in;
`ifdef ALU8_SEQ_CHAIN_EN
          if (bus.chain) begin
            aluA_d  = resOut_q;
            state_d = S_BL;
          end else begin
            state_d = S_AL;
          end
`else
          state_d = S_AL;
`endif
        end
      end
      S_AL, S_AH: begin
        collSrc  = aluA_q;
        collHi   = (state_q == S_AH);
        collLoad = bus.nib_valid;
        aluA_d   = collByte;
        if (bus.nib_valid) begin
          state_d = (state_q == S_AL) ? S_AH : S_BL;
        end
      end
      S_BL, S_BH: begin
        collSrc  = aluB_q;
        collHi   = (state_q == S_BH);
        collLoad = bus.nib_valid;
        aluB_d   = collByte;
        if (bus.nib_valid) begin
          if (state_q == S_BL) begin
            state_d = S_BH;
          end else begin
            state_d   = S_EXEC;
            execCnt_d = EXEC_LOAD;
          end
        end
      end
      S_EXEC: begin
        if (execCnt_q == '0) begin
          resOut_d   = bus.alu_result;
          resValid_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          execCnt_d = execCnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (resValid_q && bus.res_ready) begin
          resValid_d = 1'b0;
          state_d    = S_OP;
        end
      end
      default: begin
        state_d = S_OP;
      end
    endcase
  end

  alu8_nib_collector u_collector (
    .byte_i   (collSrc),
    .nib_i    (bus.nib_in),
    .hi_sel_i (collHi),
    .load_i   (collLoad),
    .byte_o   (collByte)
  );

  // State, operand, counter and result registers; reset drops any partial or pending command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OP;
      execCnt_q  <= '0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluOp_q    <= '0;
      resOut_q   <= '0;
      resValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      execCnt_q  <= execCnt_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluOp_q    <= aluOp_d;
      resOut_q   <= resOut_d;
      resValid_q <= resValid_d;
    end
  end

  assign bus.nib_ready = nibReady;
  assign bus.busy      = (state_q != S_OP);
  assign bus.res_out   = resOut_q;
  assign bus.res_valid = resValid_q;
  assign bus.alu_a     = aluA_q;
  assign bus.alu_b     = aluB_q;
  assign bus.alu_op    = aluOp_q;

endmodule
